// File: rtl/axi_lite_join_bridge.sv
// AXI-Lite front-end bridge: buffers AW/W/AR independently, joins AW+W into a
// single-cycle downstream write, runs one transaction at a time with a response timeout.
module axi_lite_join_bridge #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clock,
  input  logic                reset,
  // Upstream write address
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awvalid,
  output logic                s_awready,
  // Upstream write data
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wvalid,
  output logic                s_wready,
  // Upstream write response
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  // Upstream read address
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  // Upstream read data
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rvalid,
  input  logic                s_rready,
  // Downstream slave
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rvalid,
  output logic                m_rready
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned CntW  = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = '1;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StWrIssue,
    StWrWait,
    StWrResp,
    StRdIssue,
    StRdWait,
    StRdResp
  } state_e;

  state_e state_q, state_d;
  logic   last_rd_q, last_rd_d;

  logic              aw_full_q, aw_full_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              w_full_q, w_full_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [StrbW-1:0]  w_strb_q, w_strb_d;
  logic              ar_full_q, ar_full_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;

  logic [ADDR_W-1:0] m_awaddr_q, m_awaddr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [StrbW-1:0]  m_wstrb_q, m_wstrb_d;
  logic [ADDR_W-1:0] m_araddr_q, m_araddr_d;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic aw_hs, w_hs, ar_hs;
  logic wr_elig, rd_elig, tie, grant_wr, grant_rd;

  assign s_awready = !aw_full_q && !reset;
  assign s_wready  = !w_full_q && !reset;
  assign s_arready = !ar_full_q && !reset;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;
  assign ar_hs = s_arvalid && s_arready;

  // A handshake completing this cycle counts as buffered, so issue follows the next edge.
  assign wr_elig  = (aw_full_q || aw_hs) && (w_full_q || w_hs);
  assign rd_elig  = ar_full_q || ar_hs;
  assign tie      = wr_elig && rd_elig;
  assign grant_wr = wr_elig && (!rd_elig || last_rd_q);
  assign grant_rd = rd_elig && !grant_wr;

  always_comb begin
    state_d    = state_q;
    last_rd_d  = last_rd_q;
    aw_full_d  = aw_full_q || aw_hs;
    aw_addr_d  = aw_hs ? s_awaddr : aw_addr_q;
    w_full_d   = w_full_q || w_hs;
    w_data_d   = w_hs ? s_wdata : w_data_q;
    w_strb_d   = w_hs ? s_wstrb : w_strb_q;
    ar_full_d  = ar_full_q || ar_hs;
    ar_addr_d  = ar_hs ? s_araddr : ar_addr_q;
    m_awaddr_d = m_awaddr_q;
    m_wdata_d  = m_wdata_q;
    m_wstrb_d  = m_wstrb_q;
    m_araddr_d = m_araddr_q;
    cnt_d      = cnt_q;
    bresp_d    = bresp_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;

    unique case (state_q)
      StIdle: begin
        if (grant_wr) begin
          state_d    = StWrIssue;
          m_awaddr_d = aw_full_q ? aw_addr_q : s_awaddr;
          m_wdata_d  = w_full_q ? w_data_q : s_wdata;
          m_wstrb_d  = w_full_q ? w_strb_q : s_wstrb;
          cnt_d      = '0;
        end else if (grant_rd) begin
          state_d    = StRdIssue;
          m_araddr_d = ar_full_q ? ar_addr_q : s_araddr;
          cnt_d      = '0;
        end
        // Arbitration history only advances on contested grants.
        if (tie) begin
          last_rd_d = grant_rd;
        end
      end
      StWrIssue: begin
        aw_full_d = 1'b0;
        w_full_d  = 1'b0;
        if (m_bvalid) begin
          bresp_d = m_bresp;
          state_d = StWrResp;
        end else begin
          state_d = StWrWait;
        end
      end
      StWrWait: begin
        if (m_bvalid) begin
          bresp_d = m_bresp;
          state_d = StWrResp;
        end else if (cnt_q == CntLast) begin
          bresp_d = RespSlvErr;
          state_d = StWrResp;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWrResp: begin
        if (s_bready) begin
          state_d = StIdle;
        end
      end
      StRdIssue: begin
        ar_full_d = 1'b0;
        if (m_rvalid) begin
          rdata_d = m_rdata;
          rresp_d = RespOkay;
          state_d = StRdResp;
        end else begin
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (m_rvalid) begin
          rdata_d = m_rdata;
          rresp_d = RespOkay;
          state_d = StRdResp;
        end else if (cnt_q == CntLast) begin
          rdata_d = '0;
          rresp_d = RespSlvErr;
          state_d = StRdResp;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRdResp: begin
        if (s_rready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      last_rd_q  <= 1'b1;
      aw_full_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      ar_full_q  <= 1'b0;
      ar_addr_q  <= '0;
      m_awaddr_q <= '0;
      m_wdata_q  <= '0;
      m_wstrb_q  <= '0;
      m_araddr_q <= '0;
      cnt_q      <= '0;
      bresp_q    <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_rd_q  <= last_rd_d;
      aw_full_q  <= aw_full_d;
      aw_addr_q  <= aw_addr_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      ar_full_q  <= ar_full_d;
      ar_addr_q  <= ar_addr_d;
      m_awaddr_q <= m_awaddr_d;
      m_wdata_q  <= m_wdata_d;
      m_wstrb_q  <= m_wstrb_d;
      m_araddr_q <= m_araddr_d;
      cnt_q      <= cnt_d;
      bresp_q    <= bresp_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign m_awvalid = (state_q == StWrIssue);
  assign m_wvalid  = (state_q == StWrIssue);
  assign m_arvalid = (state_q == StRdIssue);
  assign m_rready  = (state_q == StRdIssue) || (state_q == StRdWait);
  assign m_awaddr  = m_awaddr_q;
  assign m_wdata   = m_wdata_q;
  assign m_wstrb   = m_wstrb_q;
  assign m_araddr  = m_araddr_q;

  assign s_bvalid = (state_q == StWrResp);
  assign s_bresp  = bresp_q;
  assign s_rvalid = (state_q == StRdResp);
  assign s_rdata  = rdata_q;
  assign s_rresp  = rresp_q;

endmodule

// File: tb/tb_axi_lite_join_bridge.sv
// Directed bench for axi_lite_join_bridge: inputs change 1 time unit after the
// rising edge, outputs are checked on the falling edge.
module tb_axi_lite_join_bridge;

  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 8;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [ADDR_W-1:0]   s_awaddr = '0;
  logic                s_awvalid = 1'b0;
  logic                s_awready;
  logic [DATA_W-1:0]   s_wdata = '0;
  logic [DATA_W/8-1:0] s_wstrb = '0;
  logic                s_wvalid = 1'b0;
  logic                s_wready;
  logic [1:0]          s_bresp;
  logic                s_bvalid;
  logic                s_bready = 1'b0;
  logic [ADDR_W-1:0]   s_araddr = '0;
  logic                s_arvalid = 1'b0;
  logic                s_arready;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rvalid;
  logic                s_rready = 1'b0;
  logic [ADDR_W-1:0]   m_awaddr;
  logic                m_awvalid;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                m_wvalid;
  logic [1:0]          m_bresp = '0;
  logic                m_bvalid = 1'b0;
  logic [ADDR_W-1:0]   m_araddr;
  logic                m_arvalid;
  logic [DATA_W-1:0]   m_rdata = '0;
  logic                m_rvalid = 1'b0;
  logic                m_rready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  axi_lite_join_bridge #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .s_awaddr (s_awaddr),
    .s_awvalid(s_awvalid),
    .s_awready(s_awready),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_wvalid (s_wvalid),
    .s_wready (s_wready),
    .s_bresp  (s_bresp),
    .s_bvalid (s_bvalid),
    .s_bready (s_bready),
    .s_araddr (s_araddr),
    .s_arvalid(s_arvalid),
    .s_arready(s_arready),
    .s_rdata  (s_rdata),
    .s_rresp  (s_rresp),
    .s_rvalid (s_rvalid),
    .s_rready (s_rready),
    .m_awaddr (m_awaddr),
    .m_awvalid(m_awvalid),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_wvalid (m_wvalid),
    .m_bresp  (m_bresp),
    .m_bvalid (m_bvalid),
    .m_araddr (m_araddr),
    .m_arvalid(m_arvalid),
    .m_rdata  (m_rdata),
    .m_rvalid (m_rvalid),
    .m_rready (m_rready)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset cycle: upstream readies held low
    nxt();
    mid();
    check_eq("rst_awready", 64'(s_awready), 64'd0);
    check_eq("rst_arready", 64'(s_arready), 64'd0);
    nxt();
    reset = 1'b0;

    // ---------------- Write: AW then W three cycles later ----------------
    mid();
    check_eq("idle_awready", 64'(s_awready), 64'd1);
    check_eq("idle_wready", 64'(s_wready), 64'd1);
    check_eq("idle_arready", 64'(s_arready), 64'd1);
    check_eq("idle_bvalid", 64'(s_bvalid), 64'd0);
    check_eq("idle_rvalid", 64'(s_rvalid), 64'd0);
    check_eq("idle_m_awaddr", 64'(m_awaddr), 64'd0);
    nxt();
    s_awvalid = 1'b1; s_awaddr = 6'h08;
    mid();
    check_eq("wr_aw_ready", 64'(s_awready), 64'd1);
    nxt();
    s_awvalid = 1'b0;
    mid();
    check_eq("wr_aw_full", 64'(s_awready), 64'd0);
    check_eq("wr_no_early_aw", 64'(m_awvalid), 64'd0);
    nxt();
    mid();
    check_eq("wr_no_early_aw2", 64'(m_awvalid), 64'd0);
    nxt();
    s_wvalid = 1'b1; s_wdata = 32'hA5A5_0001; s_wstrb = 4'hF;
    mid();
    check_eq("wr_w_ready", 64'(s_wready), 64'd1);
    check_eq("wr_no_aw_in_w_cycle", 64'(m_awvalid), 64'd0);
    nxt();
    s_wvalid = 1'b0;
    mid();
    check_eq("wr_m_awvalid", 64'(m_awvalid), 64'd1);
    check_eq("wr_m_wvalid", 64'(m_wvalid), 64'd1);
    check_eq("wr_m_awaddr", 64'(m_awaddr), 64'h08);
    check_eq("wr_m_wdata", 64'(m_wdata), 64'hA5A5_0001);
    check_eq("wr_m_wstrb", 64'(m_wstrb), 64'hF);
    nxt();
    m_bvalid = 1'b1; m_bresp = 2'b00;
    mid();
    check_eq("wr_awvalid_one_cycle", 64'(m_awvalid), 64'd0);
    check_eq("wr_wvalid_one_cycle", 64'(m_wvalid), 64'd0);
    check_eq("wr_bvalid_not_yet", 64'(s_bvalid), 64'd0);
    nxt();
    m_bvalid = 1'b0;
    s_awvalid = 1'b1; s_awaddr = 6'h0C;
    mid();
    check_eq("wr_bvalid", 64'(s_bvalid), 64'd1);
    check_eq("wr_bresp", 64'(s_bresp), 64'd0);
    check_eq("wr_m_awaddr_hold", 64'(m_awaddr), 64'h08);
    nxt();
    s_awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mid();
      check_eq("wr_bvalid_stall", 64'(s_bvalid), 64'd1);
      check_eq("wr_awready_stall", 64'(s_awready), 64'd0);
      nxt();
    end
    s_bready = 1'b1;
    mid();
    check_eq("wr_bvalid_at_accept", 64'(s_bvalid), 64'd1);
    nxt();
    s_bready = 1'b0;
    s_wvalid = 1'b1; s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'h3;
    mid();
    check_eq("wr_bvalid_drop", 64'(s_bvalid), 64'd0);
    nxt();
    s_wvalid = 1'b0;
    m_bvalid = 1'b1; m_bresp = 2'b01;  // response during the issue cycle
    mid();
    check_eq("wr2_m_awvalid", 64'(m_awvalid), 64'd1);
    check_eq("wr2_m_awaddr", 64'(m_awaddr), 64'h0C);
    check_eq("wr2_m_wdata", 64'(m_wdata), 64'hDEAD_BEEF);
    check_eq("wr2_m_wstrb", 64'(m_wstrb), 64'h3);
    nxt();
    m_bvalid = 1'b0; s_bready = 1'b1;
    mid();
    check_eq("wr2_bvalid", 64'(s_bvalid), 64'd1);
    check_eq("wr2_bresp", 64'(s_bresp), 64'd1);
    nxt();
    s_bready = 1'b0;

    // ---------------- Read with a second AR queued ----------------
    s_arvalid = 1'b1; s_araddr = 6'h10;
    mid();
    check_eq("rd_arready", 64'(s_arready), 64'd1);
    check_eq("rd_bvalid_clear", 64'(s_bvalid), 64'd0);
    nxt();
    s_arvalid = 1'b0;
    mid();
    check_eq("rd_m_arvalid", 64'(m_arvalid), 64'd1);
    check_eq("rd_m_araddr", 64'(m_araddr), 64'h10);
    check_eq("rd_m_rready_issue", 64'(m_rready), 64'd1);
    nxt();
    s_arvalid = 1'b1; s_araddr = 6'h14;
    mid();
    check_eq("rd_ar2_ready", 64'(s_arready), 64'd1);
    check_eq("rd_arvalid_one_cycle", 64'(m_arvalid), 64'd0);
    check_eq("rd_m_rready_wait", 64'(m_rready), 64'd1);
    nxt();
    s_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
    mid();
    check_eq("rd_ar2_buffered", 64'(s_arready), 64'd0);
    check_eq("rd_rvalid_not_yet", 64'(s_rvalid), 64'd0);
    nxt();
    m_rvalid = 1'b0; s_rready = 1'b1;
    mid();
    check_eq("rd_rvalid", 64'(s_rvalid), 64'd1);
    check_eq("rd_rdata", 64'(s_rdata), 64'h1234_5678);
    check_eq("rd_rresp", 64'(s_rresp), 64'd0);
    check_eq("rd_no_issue_in_resp", 64'(m_arvalid), 64'd0);
    nxt();
    s_rready = 1'b0;
    mid();
    check_eq("rd_rvalid_drop", 64'(s_rvalid), 64'd0);
    check_eq("rd_ar2_not_yet", 64'(m_arvalid), 64'd0);
    nxt();
    mid();
    check_eq("rd_ar2_issue", 64'(m_arvalid), 64'd1);
    check_eq("rd_ar2_addr", 64'(m_araddr), 64'h14);
    nxt();
    m_rvalid = 1'b1; m_rdata = 32'hCAFE_0002;
    nxt();
    m_rvalid = 1'b0; s_rready = 1'b1;
    mid();
    check_eq("rd_ar2_rdata", 64'(s_rdata), 64'hCAFE_0002);
    nxt();
    s_rready = 1'b0;

    // ---------------- Tie arbitration after a fresh reset ----------------
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    s_awvalid = 1'b1; s_awaddr = 6'h18;
    s_wvalid = 1'b1; s_wdata = 32'h0000_0011; s_wstrb = 4'hF;
    s_arvalid = 1'b1; s_araddr = 6'h1C;
    nxt();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    m_bvalid = 1'b1; m_bresp = 2'b00;
    mid();
    check_eq("tie1_write_first", 64'(m_awvalid), 64'd1);
    check_eq("tie1_read_waits", 64'(m_arvalid), 64'd0);
    nxt();
    m_bvalid = 1'b0; s_bready = 1'b1;
    nxt();
    s_bready = 1'b0;
    mid();
    check_eq("tie1_read_not_yet", 64'(m_arvalid), 64'd0);
    nxt();
    m_rvalid = 1'b1; m_rdata = 32'h0000_0055;
    mid();
    check_eq("tie1_read_second", 64'(m_arvalid), 64'd1);
    check_eq("tie1_read_addr", 64'(m_araddr), 64'h1C);
    nxt();
    m_rvalid = 1'b0; s_rready = 1'b1;
    mid();
    check_eq("tie1_rdata", 64'(s_rdata), 64'h55);
    nxt();
    s_rready = 1'b0;
    s_awvalid = 1'b1; s_awaddr = 6'h20;
    s_wvalid = 1'b1; s_wdata = 32'h0000_0022; s_wstrb = 4'h1;
    s_arvalid = 1'b1; s_araddr = 6'h24;
    nxt();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h0000_0066;
    mid();
    check_eq("tie2_read_first", 64'(m_arvalid), 64'd1);
    check_eq("tie2_write_waits", 64'(m_awvalid), 64'd0);
    check_eq("tie2_read_addr", 64'(m_araddr), 64'h24);
    nxt();
    m_rvalid = 1'b0; s_rready = 1'b1;
    nxt();
    s_rready = 1'b0;
    nxt();
    m_bvalid = 1'b1; m_bresp = 2'b00;
    mid();
    check_eq("tie2_write_second", 64'(m_awvalid), 64'd1);
    check_eq("tie2_write_addr", 64'(m_awaddr), 64'h20);
    nxt();
    m_bvalid = 1'b0; s_bready = 1'b1;
    nxt();
    s_bready = 1'b0;

    // ---------------- Read timeout (TIMEOUT = 8 wait cycles) ----------------
    s_arvalid = 1'b1; s_araddr = 6'h28;
    nxt();
    s_arvalid = 1'b0;
    mid();
    check_eq("to_m_arvalid", 64'(m_arvalid), 64'd1);
    nxt();
    for (int i = 1; i <= int'(TIMEOUT); i++) begin
      mid();
      check_eq("to_rvalid_wait", 64'(s_rvalid), 64'd0);
      nxt();
    end
    s_rready = 1'b1;
    mid();
    check_eq("to_rvalid", 64'(s_rvalid), 64'd1);
    check_eq("to_rresp", 64'(s_rresp), 64'd2);
    check_eq("to_rdata", 64'(s_rdata), 64'd0);
    nxt();
    s_rready = 1'b0;
    s_arvalid = 1'b1; s_araddr = 6'h2C;
    nxt();
    s_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h0000_0077;
    nxt();
    m_rvalid = 1'b0; s_rready = 1'b1;
    mid();
    check_eq("post_to_rvalid", 64'(s_rvalid), 64'd1);
    check_eq("post_to_rresp", 64'(s_rresp), 64'd0);
    check_eq("post_to_rdata", 64'(s_rdata), 64'h77);
    nxt();
    s_rready = 1'b0;

    // ---------------- Stray responses and reset mid-read ----------------
    m_bvalid = 1'b1; m_rvalid = 1'b1;
    s_awvalid = 1'b1; s_awaddr = 6'h30;
    nxt();
    s_awvalid = 1'b0;
    nxt();
    m_bvalid = 1'b0; m_rvalid = 1'b0;
    mid();
    check_eq("stray_bvalid", 64'(s_bvalid), 64'd0);
    check_eq("stray_rvalid", 64'(s_rvalid), 64'd0);
    check_eq("stray_aw_held", 64'(s_awready), 64'd0);
    s_arvalid = 1'b1; s_araddr = 6'h34;
    nxt();
    s_arvalid = 1'b0;
    mid();
    check_eq("rst_rd_issue", 64'(m_arvalid), 64'd1);
    nxt();
    reset = 1'b1;
    mid();
    check_eq("rst_mid_awready", 64'(s_awready), 64'd0);
    check_eq("rst_mid_wready", 64'(s_wready), 64'd0);
    nxt();
    reset = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h0000_0099;
    mid();
    check_eq("post_rst_awready", 64'(s_awready), 64'd1);
    check_eq("post_rst_wready", 64'(s_wready), 64'd1);
    check_eq("post_rst_arready", 64'(s_arready), 64'd1);
    check_eq("post_rst_m_arvalid", 64'(m_arvalid), 64'd0);
    check_eq("post_rst_m_rready", 64'(m_rready), 64'd0);
    nxt();
    m_rvalid = 1'b0;
    mid();
    check_eq("post_rst_no_rvalid", 64'(s_rvalid), 64'd0);
    check_eq("post_rst_no_bvalid", 64'(s_bvalid), 64'd0);
    check_eq("post_rst_no_awvalid", 64'(m_awvalid), 64'd0);
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_join_bridge.md
Name: axi_lite_join_bridge

Overview:
- Front-end adapter placed directly upstream of the processor AXI-Lite control slave, between the host AXI-Lite interconnect and the slave.
- The slave ties its awready, wready and arready high and has no bready or response handshake, so it depends on well-formed single-beat stimulus.
- This bridge provides full AXI-Lite handshakes upstream and buffers AW and W independently. It joins them into a single-cycle downstream write, runs one transaction at a time, and applies a response timeout with SLVERR.

Parameters:
- ADDR_W, 6, address width on both sides.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- TIMEOUT, 1024, number of wait cycles for a downstream response before SLVERR is returned.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- s_awaddr  in  ADDR_W  upstream write address.
- s_awvalid  in  1
- s_awready  out  1
- s_wdata  in  DATA_W
- s_wstrb  in  DATA_W/8
- s_wvalid  in  1
- s_wready  out  1
- s_bresp  out  2
- s_bvalid  out  1
- s_bready  in  1
- s_araddr  in  ADDR_W
- s_arvalid  in  1
- s_arready  out  1
- s_rdata  out  DATA_W
- s_rresp  out  2
- s_rvalid  out  1
- s_rready  in  1
- m_awaddr  out  ADDR_W  to slave.
- m_awvalid  out  1
- m_wdata  out  DATA_W
- m_wstrb  out  DATA_W/8
- m_wvalid  out  1
- m_bresp  in  2
- m_bvalid  in  1
- m_araddr  out  ADDR_W
- m_arvalid  out  1
- m_rdata  in  DATA_W
- m_rvalid  in  1
- m_rready  out  1

Behaviour:
- Buffers: one-entry AW, W and AR holding registers.
  - s_awready = !aw_full && !reset; s_wready and s_arready are defined the same way.
  - A handshake (valid && ready) loads the entry at the clock edge.
  - AW and W may arrive in any order and in different cycles, including while another transaction is in flight.
- FSM states: IDLE, WR_ISSUE, WR_WAIT, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP.
- IDLE transitions:
  - Write eligible when aw_full && w_full; read eligible when ar_full.
  - If both are eligible, grant the opposite of last_grant. After reset last_grant = read, so the first tie goes to the write.
  - A write grant moves to WR_ISSUE; a read grant moves to RD_ISSUE.
- WR_ISSUE (exactly 1 cycle):
  - m_awvalid = m_wvalid = 1, with the buffered addr, data and strb.
  - The AW and W entries clear at the end of the cycle; the next state is WR_WAIT.
  - An m_bvalid seen in this cycle is captured as in WR_WAIT.
- WR_WAIT:
  - On m_bvalid, capture m_bresp and go to WR_RESP.
  - If the counter reaches TIMEOUT-1, capture 2'b10 (SLVERR) and go to WR_RESP.
- WR_RESP: s_bvalid = 1 holding the captured bresp; on s_bready go to IDLE.
- RD_ISSUE (exactly 1 cycle):
  - m_arvalid = 1 and m_rready = 1.
  - The AR entry clears at the end of the cycle; the next state is RD_WAIT.
  - An m_rvalid seen in this cycle is captured.
- RD_WAIT:
  - m_rready = 1.
  - On m_rvalid, capture m_rdata with rresp 2'b00 and go to RD_RESP.
  - On timeout, capture rdata 0 with rresp 2'b10.
- RD_RESP: s_rvalid = 1 holding the captured data and resp; on s_rready go to IDLE.
- Timeout counter:
  - Cleared on entry to *_ISSUE; increments each cycle in *_WAIT.
  - Width is clog2(TIMEOUT)+1 and it saturates.
- Stray responses: m_bvalid or m_rvalid outside its own ISSUE/WAIT state is ignored and does not change state.
- Downstream valids:
  - Each m_*valid is high for exactly one cycle per transaction and is registered from state, not combinational from upstream inputs.
  - Outside ISSUE, m_* address/data outputs hold their last values.
- Latency:
  - Write: the AW and W handshakes complete at edge N (last of the two); m_awvalid is high in cycle N+1; s_bvalid is asserted the cycle after m_bvalid.
  - Read: arvalid handshake at edge N; m_arvalid in cycle N+1; s_rvalid is asserted the cycle after m_rvalid.
- Reset: every output is 0, buffers are empty, state is IDLE, and last_grant = read.
  - Reset mid-transaction drops all buffered and in-flight transactions; no response is produced.
  - Upstream readies are 0 during the reset cycle.

Test Plan:
- Write with AW at cycle 2 and W at cycle 5 (addr 0x08, data 0xA5A5_0001, strb 0xF); the slave returns bvalid with bresp 0 in cycle 7 → m_awvalid and m_wvalid high only in cycle 6, and s_bvalid rises with bresp 0 the cycle after the slave's bvalid. With s_bready held low for 3 cycles, s_bvalid stays high and s_awready stays low.
- Read of addr 0x10; the slave returns rdata 0x1234_5678 two cycles after m_arvalid → s_rdata 0x1234_5678 with rresp 0. A second arvalid presented while the first is in flight is accepted into the buffer, then issued after RD_RESP completes.
- AW+W and AR are all buffered in the same cycle after reset → the write issues first, then the read. Repeating the tie → the read issues first.
- TIMEOUT=8 and the slave never responds to a read → s_rvalid exactly 8 wait cycles after m_arvalid, with rresp 2'b10 and rdata 0. The next transaction proceeds normally.
- Stray m_bvalid pulses in IDLE, and reset asserted during RD_WAIT → no s_bvalid/s_rvalid is produced; after reset all buffers are empty and the readies return to 1.
